pin_lock_controller: RTL and testbench

- Parametrised successor to the phone PIN lock.
- Takes digit-serial PIN entry over a valid/ready handshake and compares it against a stored, run-time changeable PIN.
- Locks out after repeated failures; each lockout lasts twice as long as the previous one, up to a cap.
- Sits between the keypad scanner and the phone unlock/status logic.

---
 rtl/pin_lock_pkg.sv | 28 ++
 rtl/digit_shift_collector.sv | 61 ++++++
 rtl/pin_lock_controller.sv | 168 ++++++++++++++++
 tb/tb_pin_lock_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_lock_pkg.sv
// Shared types and sizing helpers for the PIN lock controller and its digit collector.
package pin_lock_pkg;

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2,
        NEWPIN = 2'd3
    } state_t;

    // Wide enough to hold the longest lockout, LOCK_BASE << LOCK_MAX_SHIFT.
    function automatic int timer_width(input int base, input int max_shift);
        return $clog2(base << max_shift) + 1;
    endfunction

    function automatic int attempts_width(input int max_attempts);
        return $clog2(max_attempts + 1);
    endfunction

    function automatic int level_width(input int max_shift);
        return (max_shift > 0) ? $clog2(max_shift + 1) : 1;
    endfunction

    function automatic logic [31:0] lock_duration(input int base, input int level);
        return 32'(base) << level;
    endfunction

endpackage

// File: rtl/digit_shift_collector.sv
// Shift buffer plus digit index; the first digit accepted ends up as the MS digit.
module digit_shift_collector #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            accept,
    input  logic                            clear,
    input  logic [DIGIT_W-1:0]              digit,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   buffer,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   shifted,
    output logic                            done
);

    localparam int PIN_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [PIN_W-1:0] buffer_reg;
    logic [PIN_W-1:0] buffer_next;
    logic [IDX_W-1:0] index_reg;
    logic [IDX_W-1:0] index_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_shift
            if (gi == 0) begin : g_lsd
                assign shifted[DIGIT_W-1:0] = digit;
            end else begin : g_upper
                assign shifted[gi*DIGIT_W +: DIGIT_W] = buffer_reg[(gi-1)*DIGIT_W +: DIGIT_W];
            end
        end
    endgenerate

    assign done   = accept && !clear && (index_reg == LAST_IDX);
    assign buffer = buffer_reg;

    always_comb begin
        buffer_next = buffer_reg;
        index_next  = index_reg;
        if (clear) begin
            buffer_next = '0;
            index_next  = '0;
        end else if (accept) begin
            buffer_next = shifted;
            index_next  = done ? '0 : index_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer_reg <= '0;
            index_reg  <= '0;
        end else begin
            buffer_reg <= buffer_next;
            index_reg  <= index_next;
        end
    end

endmodule

// File: rtl/pin_lock_controller.sv
// Digit-serial PIN checker with run-time PIN change and doubling lockout after repeated failures.
module pin_lock_controller
    import pin_lock_pkg::*;
#(
    parameter int DIGIT_W        = 4,
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCK_BASE      = 5,
    parameter int LOCK_MAX_SHIFT = 3,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_PIN = 16'h8642,
    localparam int TIMER_W = timer_width(LOCK_BASE, LOCK_MAX_SHIFT),
    localparam int ATT_W   = attempts_width(MAX_ATTEMPTS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                digit_valid,
    input  logic [DIGIT_W-1:0]  digit_in,
    output logic                digit_ready,
    input  logic                clear,
    input  logic                change_req,
    output logic                access_granted,
    output logic                access_denied,
    output logic                pin_updated,
    output logic                locked,
    output logic [TIMER_W-1:0]  lock_remaining,
    output logic [ATT_W-1:0]    attempts_left
);

    localparam int PIN_W = DIGIT_W * NUM_DIGITS;
    localparam int LVL_W = level_width(LOCK_MAX_SHIFT);
    localparam logic [ATT_W-1:0] MAX_CNT = ATT_W'(MAX_ATTEMPTS);
    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(LOCK_MAX_SHIFT);

    state_t             state_reg,      state_next;
    logic [ATT_W-1:0]   fail_cnt_reg,   fail_cnt_next;
    logic [LVL_W-1:0]   lock_level_reg, lock_level_next;
    logic [TIMER_W-1:0] timer_reg,      timer_next;
    logic               locked_reg,     locked_next;
    logic [PIN_W-1:0]   stored_pin_reg, stored_pin_next;
    logic               granted_reg,    granted_next;
    logic               denied_reg,     denied_next;
    logic               updated_reg,    updated_next;

    logic [PIN_W-1:0]   buffer;
    logic [PIN_W-1:0]   shifted;
    logic               collect_done;
    logic               collect_accept;
    logic               collect_clear;
    logic [ATT_W-1:0]   fail_inc;
    logic [31:0]        lock_dur;

    assign digit_ready    = (state_reg == ENTRY) || (state_reg == NEWPIN);
    // clear outranks a same-cycle digit, and is ignored whenever digits are not being taken.
    assign collect_clear  = clear && digit_ready;
    assign collect_accept = digit_valid && digit_ready && !clear;

    digit_shift_collector #(
        .DIGIT_W    (DIGIT_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_collector (
        .clk     (clk),
        .reset_n (reset_n),
        .accept  (collect_accept),
        .clear   (collect_clear),
        .digit   (digit_in),
        .buffer  (buffer),
        .shifted (shifted),
        .done    (collect_done)
    );

    assign fail_inc = fail_cnt_reg + 1'b1;
    assign lock_dur = lock_duration(LOCK_BASE, int'(lock_level_reg));

    always_comb begin
        state_next      = state_reg;
        fail_cnt_next   = fail_cnt_reg;
        lock_level_next = lock_level_reg;
        timer_next      = timer_reg;
        locked_next     = locked_reg;
        stored_pin_next = stored_pin_reg;
        granted_next    = 1'b0;
        denied_next     = 1'b0;
        updated_next    = 1'b0;

        case (state_reg)
            ENTRY: begin
                if (collect_done) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (buffer == stored_pin_reg) begin
                    granted_next    = 1'b1;
                    fail_cnt_next   = '0;
                    lock_level_next = '0;
                    state_next      = change_req ? NEWPIN : ENTRY;
                end else begin
                    denied_next = 1'b1;
                    if (fail_inc == MAX_CNT) begin
                        state_next    = LOCKED;
                        timer_next    = lock_dur[TIMER_W-1:0];
                        locked_next   = 1'b1;
                        fail_cnt_next = '0;
                        if (lock_level_reg != MAX_LVL) begin
                            lock_level_next = lock_level_reg + 1'b1;
                        end
                    end else begin
                        fail_cnt_next = fail_inc;
                        state_next    = ENTRY;
                    end
                end
            end
            LOCKED: begin
                if (timer_reg == TIMER_W'(1)) begin
                    timer_next  = '0;
                    locked_next = 1'b0;
                    state_next  = ENTRY;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            NEWPIN: begin
                if (clear) begin
                    state_next = ENTRY;
                end else if (collect_done) begin
                    stored_pin_next = shifted;
                    updated_next    = 1'b1;
                    state_next      = ENTRY;
                end
            end
            default: begin
                state_next = ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ENTRY;
            fail_cnt_reg   <= '0;
            lock_level_reg <= '0;
            timer_reg      <= '0;
            locked_reg     <= 1'b0;
            stored_pin_reg <= DEFAULT_PIN;
            granted_reg    <= 1'b0;
            denied_reg     <= 1'b0;
            updated_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fail_cnt_reg   <= fail_cnt_next;
            lock_level_reg <= lock_level_next;
            timer_reg      <= timer_next;
            locked_reg     <= locked_next;
            stored_pin_reg <= stored_pin_next;
            granted_reg    <= granted_next;
            denied_reg     <= denied_next;
            updated_reg    <= updated_next;
        end
    end

    assign access_granted = granted_reg;
    assign access_denied  = denied_reg;
    assign pin_updated    = updated_reg;
    assign locked         = locked_reg;
    assign lock_remaining = timer_reg;
    assign attempts_left  = MAX_CNT - fail_cnt_reg;

endmodule

// File: tb/tb_pin_lock_controller.sv
// Randomized bench for pin_lock_controller against a transaction-level model of PIN, failures and lockouts.
module tb_pin_lock_controller;

    localparam int MAX_ATT   = 3;
    localparam int BASE      = 5;
    localparam int MAX_SHIFT = 3;
    localparam logic [15:0] DEF_PIN = 16'h8642;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        digit_valid;
    logic [3:0]  digit_in;
    logic        digit_ready;
    logic        clear;
    logic        change_req;
    logic        access_granted;
    logic        access_denied;
    logic        pin_updated;
    logic        locked;
    logic [6:0]  lock_remaining;
    logic [1:0]  attempts_left;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: the stored PIN, consecutive failures and how many lockouts have escalated.
    logic [15:0] m_pin;
    int          m_fails;
    int          m_level;

    always #5 clk = ~clk;

    pin_lock_controller dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .digit_valid    (digit_valid),
        .digit_in       (digit_in),
        .digit_ready    (digit_ready),
        .clear          (clear),
        .change_req     (change_req),
        .access_granted (access_granted),
        .access_denied  (access_denied),
        .pin_updated    (pin_updated),
        .locked         (locked),
        .lock_remaining (lock_remaining),
        .attempts_left  (attempts_left)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pin   = DEF_PIN;
        m_fails = 0;
        m_level = 0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        int guard;
        digit_valid = 1'b0;
        digit_in    = 4'($urandom);
        repeat ($urandom_range(0, 2)) step();
        digit_valid = 1'b1;
        digit_in    = d;
        guard       = 0;
        while (!digit_ready && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) chk("ready_timeout", 0, 1);
        step();
        digit_valid = 1'b0;
    endtask

    task automatic try_pin(input logic [15:0] pin, input bit change, output int dur);
        bit match;
        change_req = change;
        for (int k = 3; k >= 0; k--) send_digit(pin[k*4 +: 4]);
        chk("check_ready", digit_ready, 0);
        chk("early_pulse", access_granted | access_denied, 0);
        step();
        change_req = 1'b0;
        match = (pin == m_pin);
        dur   = 0;
        if (match) begin
            m_fails = 0;
            m_level = 0;
        end else begin
            m_fails++;
            if (m_fails == MAX_ATT) begin
                dur     = BASE << m_level;
                m_fails = 0;
                if (m_level < MAX_SHIFT) m_level++;
            end
        end
        chk("granted", access_granted, match);
        chk("denied", access_denied, !match);
        chk("attempts_left", attempts_left, MAX_ATT - m_fails);
        chk("locked_start", locked, dur != 0);
        $display("attempt pin=%h change=%0d granted=%0d denied=%0d attempts_left=%0d lock=%0d",
                 pin, change, access_granted, access_denied, attempts_left, dur);
        if (dur == 0) begin
            step();
            chk("pulse_once", access_granted | access_denied, 0);
        end
    endtask

    task automatic check_lockout(input int dur);
        for (int i = 0; i < dur; i++) begin
            chk("lock_locked", locked, 1);
            chk("lock_remaining", lock_remaining, dur - i);
            chk("lock_ready", digit_ready, 0);
            digit_valid = 1'($urandom_range(0, 1));
            digit_in    = 4'($urandom);
            clear       = 1'($urandom_range(0, 1));
            step();
        end
        digit_valid = 1'b0;
        clear       = 1'b0;
        chk("unlock", locked, 0);
        chk("unlock_remaining", lock_remaining, 0);
        chk("unlock_ready", digit_ready, 1);
        chk("unlock_attempts", attempts_left, MAX_ATT);
        $display("lockout of %0d cycles ended", dur);
    endtask

    task automatic new_pin(input logic [15:0] pin, input int abort_at);
        int cnt;
        if (abort_at < 4) begin
            for (int k = 3; k > 3 - abort_at; k--) send_digit(pin[k*4 +: 4]);
            clear       = 1'b1;
            digit_valid = 1'($urandom_range(0, 1));
            step();
            clear       = 1'b0;
            digit_valid = 1'b0;
            step();
            chk("no_update_on_abort", pin_updated, 0);
            $display("newpin %h aborted after %0d digits", pin, abort_at);
        end else begin
            for (int k = 3; k >= 0; k--) send_digit(pin[k*4 +: 4]);
            cnt = int'(pin_updated);
            step();
            cnt += int'(pin_updated);
            step();
            cnt += int'(pin_updated);
            chk("pin_updated_pulses", cnt, 1);
            m_pin = pin;
            $display("newpin %h stored, pin_updated pulses=%0d", pin, cnt);
        end
    endtask

    task automatic partial_clear(input int n, input bit with_digit);
        for (int k = 0; k < n; k++) send_digit(4'($urandom));
        clear       = 1'b1;
        digit_valid = with_digit;
        digit_in    = 4'($urandom);
        step();
        clear       = 1'b0;
        digit_valid = 1'b0;
        chk("clear_attempts", attempts_left, MAX_ATT - m_fails);
        chk("clear_ready", digit_ready, 1);
        $display("clear after %0d digits, same-cycle digit=%0d", n, with_digit);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        logic [15:0] pin;
        bit change;
        bit was_match;
        int r;

        reset_n     = 1'b0;
        digit_valid = 1'b0;
        digit_in    = '0;
        clear       = 1'b0;
        change_req  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", digit_ready, 1);
        chk("rst_locked", locked, 0);
        chk("rst_remaining", lock_remaining, 0);
        chk("rst_attempts", attempts_left, MAX_ATT);
        chk("rst_pulses", {access_granted, access_denied, pin_updated}, 0);
        reset_n = 1'b1;
        step();

        // Correct PIN, then recovery after a failure
        try_pin(16'h8642, 0, d);
        try_pin(16'h1111, 0, d);
        try_pin(16'h8642, 0, d);

        // First lockout and escalation to saturation
        for (int j = 0; j < 5; j++) begin
            d = 0;
            while (d == 0) try_pin(16'h1111, 0, d);
            check_lockout(d);
        end
        try_pin(16'h8642, 0, d);
        d = 0;
        while (d == 0) try_pin(16'h1111, 0, d);
        check_lockout(d);

        // clear handling
        try_pin(16'h1111, 0, d);
        partial_clear(2, 0);
        partial_clear(1, 1);
        partial_clear(0, 1);
        try_pin(16'h8642, 0, d);

        // PIN change and aborted change
        try_pin(16'h8642, 1, d);
        new_pin(16'h1234, 4);
        try_pin(16'h8642, 0, d);
        try_pin(16'h1234, 0, d);
        try_pin(16'h1234, 1, d);
        new_pin(16'h5555, 2);
        try_pin(16'h1234, 0, d);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r == 9) partial_clear($urandom_range(1, 3), 1'($urandom_range(0, 1)));
            pin       = (r < 4) ? m_pin : 16'($urandom);
            change    = (r == 0);
            was_match = (pin == m_pin);
            try_pin(pin, change, d);
            if (d != 0) check_lockout(d);
            if (change && was_match) new_pin(16'($urandom), ($urandom_range(0, 2) == 0) ? 2 : 4);
        end

        // Reset in the middle of a lockout restores everything, including the PIN
        try_pin(m_pin, 1, d);
        new_pin(16'h1357, 4);
        d = 0;
        while (d == 0) try_pin(~m_pin, 0, d);
        for (int i = 0; i < d - 3; i++) step();
        chk("pre_reset_remaining", lock_remaining, 3);
        chk("pre_reset_locked", locked, 1);
        reset_n = 1'b0;
        #2;
        chk("async_locked", locked, 0);
        chk("async_remaining", lock_remaining, 0);
        chk("async_attempts", attempts_left, MAX_ATT);
        chk("async_ready", digit_ready, 1);
        model_reset();
        step();
        reset_n = 1'b1;
        step();
        try_pin(16'h1357, 0, d);
        try_pin(16'h8642, 0, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
